// File: rtl/vf_pattern_gen.sv
// Test-pattern byte source for a USB camera core, MONO or YUY2 raster.
// Optional moving box on pattern 3: define VF_PATTERN_MOVING_BOX_EN.
module vf_pattern_gen #(
    parameter              FRAME_TYPE = "MONO",
    parameter logic [13:0] FRAME_W    = 14'd252,
    parameter logic [13:0] FRAME_H    = 14'd120
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        vf_sof,
    input  logic        vf_req,
    output logic [7:0]  vf_byte,
    input  logic [1:0]  pattern_sel,
    output logic [15:0] frame_cnt,
    output logic        frame_done,
    output logic        overrun
);

    localparam bit YUY2 = (FRAME_TYPE == "YUY2");

    logic [13:0] x_q, x_d;
    logic [13:0] y_q, y_d;
    logic [1:0]  ph_q, ph_d;
    logic        eof_q, eof_d;
    logic [1:0]  pat_q, pat_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ovr_q, ovr_d;
    logic        done_q, done_d;
    logic [7:0]  byte_q, byte_d;
`ifdef VF_PATTERN_MOVING_BOX_EN
    logic [13:0] box_q, box_d;
`endif

    logic        gen;
    logic        last;
    logic [13:0] lum_x;
    logic [16:0] x8;
    logic [2:0]  bi;
    logic [7:0]  bar;
    logic [7:0]  grad;
    logic [7:0]  lum;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        ph_d   = ph_q;
        eof_d  = eof_q;
        pat_d  = pat_q;
        cnt_d  = cnt_q;
        ovr_d  = ovr_q;
        done_d = 1'b0;
        byte_d = byte_q;
        gen    = 1'b0;
`ifdef VF_PATTERN_MOVING_BOX_EN
        box_d  = box_q;
`endif
        if (YUY2)
            last = (ph_q == 2'd3) && (x_q == FRAME_W - 14'd2)
                && (y_q == FRAME_H - 14'd1);
        else
            last = (x_q == FRAME_W - 14'd1)
                && (y_q == FRAME_H - 14'd1);

        if (vf_sof) begin
            x_d   = '0;
            y_d   = '0;
            ph_d  = '0;
            eof_d = 1'b0;
            pat_d = pattern_sel;
            cnt_d = cnt_q + 16'd1;
            ovr_d = 1'b0;
            gen   = 1'b1;
`ifdef VF_PATTERN_MOVING_BOX_EN
            if (box_q + 14'd2 > FRAME_W - 14'd16)
                box_d = '0;
            else
                box_d = box_q + 14'd2;
`endif
        end else if (vf_req) begin
            if (eof_q) begin
                ovr_d  = 1'b1;
                byte_d = '0;
            end else if (last) begin
                eof_d  = 1'b1;
                done_d = 1'b1;
                byte_d = '0;
            end else begin
                gen = 1'b1;
                // YUY2 keeps x at the even pixel of the pair; Y1 adds one
                if (YUY2) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        if (x_q == FRAME_W - 14'd2) begin
                            x_d = '0;
                            y_d = y_q + 14'd1;
                        end else begin
                            x_d = x_q + 14'd2;
                        end
                    end
                end else if (x_q == FRAME_W - 14'd1) begin
                    x_d = '0;
                    y_d = y_q + 14'd1;
                end else begin
                    x_d = x_q + 14'd1;
                end
            end
        end

        lum_x = YUY2 ? x_d + {13'd0, ph_d[1]} : x_d;
        x8    = {lum_x, 3'b000};
        bi    = 3'd0;
        for (int k = 1; k < 8; k++)
            if (x8 >= 17'(k) * {3'b000, FRAME_W})
                bi = 3'(k);
        case (bi)
            3'd0:    bar = 8'd235;
            3'd1:    bar = 8'd210;
            3'd2:    bar = 8'd170;
            3'd3:    bar = 8'd145;
            3'd4:    bar = 8'd106;
            3'd5:    bar = 8'd81;
            3'd6:    bar = 8'd41;
            default: bar = 8'd16;
        endcase
        grad = lum_x[7:0] + y_d[7:0] + cnt_d[7:0];
        case (pat_d)
            2'd1:    lum = bar;
            2'd2:    lum = (lum_x[3] ^ y_d[3]) ? 8'd235 : 8'd16;
`ifdef VF_PATTERN_MOVING_BOX_EN
            2'd3:    lum = ((y_d < 14'd16) && (lum_x >= box_d)
                           && (lum_x < box_d + 14'd16))
                           ? 8'd235 : 8'd16;
`endif
            default: lum = grad;
        endcase
        if (gen)
            byte_d = (YUY2 && ph_d[0]) ? 8'h80 : lum;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q    <= '0;
            y_q    <= '0;
            ph_q   <= '0;
            eof_q  <= 1'b1;
            pat_q  <= '0;
            cnt_q  <= '0;
            ovr_q  <= 1'b0;
            done_q <= 1'b0;
            byte_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            ph_q   <= ph_d;
            eof_q  <= eof_d;
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            ovr_q  <= ovr_d;
            done_q <= done_d;
            byte_q <= byte_d;
        end
    end

`ifdef VF_PATTERN_MOVING_BOX_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            box_q <= '0;
        else
            box_q <= box_d;
    end
`endif

    assign vf_byte    = byte_q;
    assign frame_cnt  = cnt_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/vf_pattern_gen.md
VF_PATTERN_GEN -- requirements
Module: vf_pattern_gen

Interface
REQ-001 SHALL have parameter FRAME_TYPE, default "MONO", frame format: "MONO" (1 byte/pixel) or "YUY2" (2 bytes/pixel).
REQ-002 SHALL have parameter FRAME_W, default 14'd252, frame width in pixels (even, >=16).
REQ-003 SHALL have parameter FRAME_H, default 14'd120, frame height in pixels (even, >=2).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port vf_sof  input  1  start-of-frame pulse from the USB camera core.
REQ-007 SHALL have port vf_req  input  1  byte-consume request from the USB camera core.
REQ-008 SHALL have port vf_byte  output  8  current frame byte, registered.
REQ-009 SHALL have port pattern_sel  input  2  pattern select, sampled only at vf_sof.
REQ-010 SHALL have port frame_cnt  output  16  count of vf_sof pulses since reset, wraps 0xFFFF->0.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when the last byte of a frame is consumed.
REQ-012 SHALL have port overrun  output  1  sticky flag: vf_req received after frame end.

Function
REQ-013 vf_byte SHALL always present the next unconsumed byte; a cycle with vf_req=1 consumes it and vf_byte SHALL show the following byte from the next clk edge (1-cycle latency).
REQ-014 On vf_sof=1: x=0, y=0, byte-phase=0, pattern latched from pattern_sel, frame_cnt+1, overrun cleared, vf_byte = byte 0 of the new frame computed with the incremented frame_cnt.
REQ-015 vf_sof and vf_req in the same cycle: vf_sof SHALL win; vf_req ignored.
REQ-016 Frame length N = FRAME_W*FRAME_H (MONO) or 2*FRAME_W*FRAME_H (YUY2); raster order, x fastest, x wraps FRAME_W-1->0 with y+1.
REQ-017 YUY2 byte order per pixel pair SHALL be Y0,U,Y1,V; U and V SHALL be 8'h80; x advances after each Y byte.
REQ-018 Luma, pattern 0 (gradient): (x + y + frame_cnt[7:0]) mod 256.
REQ-019 Luma, pattern 1 (bars): table {235,210,170,145,106,81,41,16} indexed by (x*8)/FRAME_W.
REQ-020 Luma, pattern 2 (checker): 235 if (x[3]^y[3]) else 16.
REQ-021 Luma, pattern 3: moving box (see Configuration).
REQ-022 When vf_req consumes byte N-1: frame_done=1 for that next cycle, vf_byte=8'h00.
REQ-023 vf_req after frame end and before next vf_sof: vf_byte SHALL stay 8'h00, counters SHALL hold, overrun SHALL set and remain 1 until next vf_sof or reset.
REQ-024 vf_req before the first vf_sof after reset SHALL be treated as after frame end (REQ-023).
REQ-025 vf_sof mid-frame SHALL abort the current frame with no frame_done pulse and restart per REQ-014.

Reset
REQ-026 rstn=0 SHALL asynchronously force vf_byte=0, frame_cnt=0, frame_done=0, overrun=0, x=0, y=0, byte-phase=0, latched pattern=0, box position=0, and set the end-of-frame state.
REQ-027 Release of rstn SHALL take effect on the first clk edge after release; no output changes until then.

Configuration
REQ-028 Macro VF_PATTERN_MOVING_BOX_EN defined: pattern 3 = 16x16 box, luma 235 inside, 16 outside; box rows 0..15, columns box_x..box_x+15.
REQ-029 box_x SHALL advance by 2 at each vf_sof and wrap to 0 when the next value would exceed FRAME_W-16.
REQ-030 Macro undefined: no box logic, no box_x register; pattern 3 SHALL produce pattern 0 output.

Verification (FRAME_W=16, FRAME_H=4 unless stated)
REQ-031 MONO, pattern 0, reset, one vf_sof, 64 vf_req -> bytes 1..16, 2..17, 3..18, 4..19 (frame_cnt=1); frame_done pulses once; vf_byte=0 afterwards.
REQ-032 MONO, pattern 1, one row -> bytes 235,235,210,210,170,170,145,145,106,106,81,81,41,41,16,16.
REQ-033 YUY2, pattern 2, first 8 bytes -> 16,80h,16,80h,16,80h,16,80h; byte 16 = 235 (x=8); N=128.
REQ-034 65th vf_req after REQ-031 -> overrun=1, vf_byte=0; next vf_sof -> overrun=0, byte 0 = 2.
REQ-035 vf_sof and vf_req together at byte 5, then rstn pulsed low mid-frame -> frame restarts at byte 0; reset clears all outputs asynchronously.
REQ-036 VF_PATTERN_MOVING_BOX_EN defined, FRAME_W=32, pattern 3, 9 frames -> box_x sequence 2,4,...,16,0; row 0 byte box_x = 235, byte box_x-1 = 16.
